// File: rtl/mux_rr_stream.sv
// mux_rr_stream: N-channel registered stream multiplexer.
// One input channel is granted per cycle and copied into a single output
// register. The grant is either the channel named by sel (RR == 0) or a
// round-robin choice starting from a rotating pointer (RR == 1).
//
// Handshake: every port pair uses plain valid/ready. A word moves only on a
// clock edge where valid && ready are both high. A source may raise valid at
// any time and must hold its data until it sees ready. ready never depends on
// the source's own data. in_ready is at most one-hot, and it is zero while rst
// is low. The output register accepts a new word whenever it is empty or is
// being drained in the same cycle. This gives one word per clock.
module mux_rr_stream #(
  parameter int  N_CH  = 4,
  parameter int  WIDTH = 8,
  parameter bit  RR    = 1'b1,
  localparam int SELW  = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SELW-1:0]         sel,
  input  logic [N_CH-1:0]         in_valid,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  output logic [N_CH-1:0]         in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SELW-1:0]         out_ch,
  input  logic                    out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_ch_q,    out_ch_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  logic             load_en;
  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic [SELW:0]    cand;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;

  assign load_en = !out_valid_q || out_ready;
  assign xfer    = rst && load_en && grant_vld;

  // Grant selection. In round-robin mode the candidates are scanned from
  // ptr upward with wrap. The scan runs in reverse, so the smallest offset
  // from ptr is the last one written and therefore wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (RR) begin
      for (int k = N_CH - 1; k >= 0; k--) begin
        cand = {1'b0, ptr_q} + (SELW+1)'(k);
        if (cand >= (SELW+1)'(N_CH)) begin
          cand = cand - (SELW+1)'(N_CH);
        end
        if (in_valid[cand[SELW-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = cand[SELW-1:0];
        end
      end
    end else begin
      if ({1'b0, sel} < (SELW+1)'(N_CH)) begin
        if (in_valid[sel]) begin
          grant_vld = 1'b1;
          grant_idx = sel;
        end
      end
    end
  end

  // Data mux for the granted channel, and the one-hot ready toward sources.
  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = rst && load_en && grant_vld;
      end
    end
  end

  // Next-state for the output register and the round-robin pointer.
  // A stalled register holds everything. An empty reload clears only the valid bit.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      out_valid_d = grant_vld;
    end
    if (xfer) begin
      out_data_d = grant_data;
      out_ch_d   = grant_idx;
      ptr_d      = (grant_idx == SELW'(N_CH - 1)) ? '0 : grant_idx + SELW'(1);
    end
  end

  // State registers with synchronous active-low reset. A word in flight is dropped on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
